// File: rtl/ifu_fetch_ctrl_pkg.sv
// Shared IFU constants: datapath widths, reset fetch address and sequencer state encoding.
package ifu_fetch_ctrl_pkg;

  localparam int          IFU_PC_SIZE    = 32;
  localparam int          IFU_INSTR_SIZE = 32;
  localparam int          RFIDX_WIDTH    = 5;
  localparam int          XLEN           = 32;
  localparam logic [31:0] IFU_RST_PC     = 32'h8000_0000;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DEP  = 2'd2,
    S_HOLD = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/ifu_bpu.sv
// Static next-PC predictor; bxx direction set by IFU_STATIC_BPU_EN (BTFN when defined, not-taken otherwise).
// Latency: purely combinational.
// Backpressure: none, evaluated every cycle.
module ifu_bpu
  import ifu_fetch_ctrl_pkg::*;
#(
  parameter int PC_SIZE = IFU_PC_SIZE
) (
  input  logic [PC_SIZE-1:0] pc,
  input  logic               jal,
  input  logic               jalr,
  input  logic               bxx,
  input  logic [XLEN-1:0]    imm,
  input  logic [XLEN-1:0]    rs1_val,
  output logic [PC_SIZE-1:0] next_pc,
  output logic               prdt_taken
);

  logic [PC_SIZE-1:0] imm_pc;
  logic               bxx_taken;

  assign imm_pc = PC_SIZE'(imm);

`ifdef IFU_STATIC_BPU_EN
  // Backward branches (negative offset) are predicted taken.
  assign bxx_taken = imm[XLEN-1];
`else
  assign bxx_taken = 1'b0;
`endif

  always_comb begin
    next_pc    = pc + PC_SIZE'(4);
    prdt_taken = 1'b0;
    if (jal) begin
      next_pc    = pc + imm_pc;
      prdt_taken = 1'b1;
    end else if (jalr) begin
      next_pc    = PC_SIZE'(rs1_val) + imm_pc;
      next_pc[0] = 1'b0;
      prdt_taken = 1'b1;
    end else if (bxx && bxx_taken) begin
      next_pc    = pc + imm_pc;
      prdt_taken = 1'b1;
    end
  end

endmodule

// File: rtl/ifu_fetch_ctrl.sv
// IFU fetch sequencer: one outstanding fetch, static next-PC (IFU_STATIC_BPU_EN), flush and JALR RAW stall.
// Latency: response in cycle N -> ir_valid in N+1; next request in N+2 when ir_ready is high.
// Backpressure: holds {instr, pc, prdt_taken} on ir_valid until ir_ready; stalls in S_DEP until oitf_empty.
module ifu_fetch_ctrl
  import ifu_fetch_ctrl_pkg::*;
#(
  parameter int                 PC_SIZE    = IFU_PC_SIZE,
  parameter int                 INSTR_SIZE = IFU_INSTR_SIZE,
  parameter logic [PC_SIZE-1:0] RST_PC     = PC_SIZE'(IFU_RST_PC)
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   ifu_req_valid,
  input  logic                   ifu_req_ready,
  output logic [PC_SIZE-1:0]     ifu_req_pc,
  input  logic                   ifu_rsp_valid,
  output logic                   ifu_rsp_ready,
  input  logic [INSTR_SIZE-1:0]  ifu_rsp_instr,
  output logic [INSTR_SIZE-1:0]  md_instr,
  input  logic                   md_jal,
  input  logic                   md_jalr,
  input  logic                   md_bxx,
  input  logic [RFIDX_WIDTH-1:0] md_jalr_rs1idx,
  input  logic [XLEN-1:0]        md_bjp_imm,
  input  logic                   oitf_empty,
  input  logic [XLEN-1:0]        jalr_rs1_rdata,
  output logic                   ir_valid,
  input  logic                   ir_ready,
  output logic [INSTR_SIZE-1:0]  ir_instr,
  output logic [PC_SIZE-1:0]     ir_pc,
  output logic                   ir_prdt_taken,
  input  logic                   flush_req,
  input  logic [PC_SIZE-1:0]     flush_pc,
  output logic                   flush_ack
);

  fetch_state_e            state_q, state_d;
  logic [PC_SIZE-1:0]      pc_r, next_pc_r, ir_pc_r;
  logic [INSTR_SIZE-1:0]   ir_instr_r;
  logic                    ir_prdt_taken_r;
  logic                    discard_r;
  logic                    ir_load, bpu_load, pc_adv;
  logic                    jalr_dep;
  logic [XLEN-1:0]         rs1_val;
  logic [PC_SIZE-1:0]      bpu_next_pc;
  logic                    bpu_taken;

  // Outside S_WAIT the minidec keeps decoding the held instruction, which S_DEP relies on.
  assign md_instr = (state_q == S_WAIT) ? ifu_rsp_instr : ir_instr_r;
  assign jalr_dep = md_jalr && (md_jalr_rs1idx != '0) && !oitf_empty;
  assign rs1_val  = (md_jalr_rs1idx == '0) ? '0 : jalr_rs1_rdata;

  ifu_bpu #(
    .PC_SIZE(PC_SIZE)
  ) u_bpu (
    .pc         (pc_r),
    .jal        (md_jal),
    .jalr       (md_jalr),
    .bxx        (md_bxx),
    .imm        (md_bjp_imm),
    .rs1_val    (rs1_val),
    .next_pc    (bpu_next_pc),
    .prdt_taken (bpu_taken)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_REQ;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    ifu_req_valid = 1'b0;
    ifu_rsp_ready = 1'b0;
    ir_valid      = 1'b0;
    flush_ack     = 1'b0;
    ir_load       = 1'b0;
    bpu_load      = 1'b0;
    pc_adv        = 1'b0;
    if (!rst) begin
      flush_ack = flush_req;
      unique case (state_q)
        S_REQ: begin
          // A flush withdraws the request; nothing is committed without valid&ready.
          ifu_req_valid = !flush_req;
          if (ifu_req_ready && !flush_req) state_d = S_WAIT;
        end
        S_WAIT: begin
          ifu_rsp_ready = 1'b1;
          if (ifu_rsp_valid) begin
            if (discard_r || flush_req) begin
              state_d = S_REQ;
            end else begin
              ir_load = 1'b1;
              if (jalr_dep) begin
                state_d = S_DEP;
              end else begin
                bpu_load = 1'b1;
                state_d  = S_HOLD;
              end
            end
          end
        end
        S_DEP: begin
          if (oitf_empty) begin
            bpu_load = 1'b1;
            state_d  = S_HOLD;
          end
        end
        S_HOLD: begin
          ir_valid = 1'b1;
          if (ir_ready) begin
            pc_adv  = 1'b1;
            state_d = S_REQ;
          end
        end
        default: state_d = S_REQ;
      endcase
      // A flush in S_WAIT without the beat keeps waiting so the stale response is drained.
      if (flush_req) state_d = (state_q == S_WAIT && !ifu_rsp_valid) ? S_WAIT : S_REQ;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r            <= RST_PC;
      discard_r       <= 1'b0;
      next_pc_r       <= '0;
      ir_pc_r         <= '0;
      ir_instr_r      <= '0;
      ir_prdt_taken_r <= 1'b0;
    end else begin
      if (flush_req)   pc_r <= flush_pc;
      else if (pc_adv) pc_r <= next_pc_r;
      if (state_q == S_WAIT) begin
        if (ifu_rsp_valid)  discard_r <= 1'b0;
        else if (flush_req) discard_r <= 1'b1;
      end
      if (ir_load) begin
        ir_instr_r <= ifu_rsp_instr;
        ir_pc_r    <= pc_r;
      end
      if (bpu_load) begin
        next_pc_r       <= bpu_next_pc;
        ir_prdt_taken_r <= bpu_taken;
      end
    end
  end

  assign ifu_req_pc    = pc_r;
  assign ir_instr      = ir_instr_r;
  assign ir_pc         = ir_pc_r;
  assign ir_prdt_taken = ir_prdt_taken_r;

endmodule
